// File: rtl/prog_pkg.sv
// Shared launcher types and the per-program end-address table.
package prog_pkg;

  localparam int NUM_PROGS_DEFAULT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FINISH,
    S_ALL_DONE
  } launch_state_e;

  localparam logic [15:0] PROG_END [3] = '{16'd123, 16'd300, 16'd511};

  // Index 3 has no program; the unreachable address keeps it from ever matching.
  function automatic logic [15:0] prog_end(input logic [1:0] idx);
    logic [15:0] addr;
    addr = 16'hFFFF;
    case (idx)
      2'd0:    addr = PROG_END[0];
      2'd1:    addr = PROG_END[1];
      2'd2:    addr = PROG_END[2];
      default: addr = 16'hFFFF;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i && (q_q != '1)) begin
      q_q <= q_q + 1'b1;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/prog_launcher.sv
// Launches NUM_PROGS programs on a fetch unit one after another, timing each run.
module prog_launcher
  import prog_pkg::*;
#(
  parameter int          NUM_PROGS   = NUM_PROGS_DEFAULT,
  parameter int          INIT_CYCLES = 2,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Done_if,
  input  logic [15:0] PC,
  output logic        Init,
  output logic        Busy,
  output logic [1:0]  Prog_idx,
  output logic [15:0] Cycle_count,
  output logic        Ready,
  output logic        Timeout,
  output logic        All_done
);

  localparam logic [7:0]  INIT_LAST    = 8'(INIT_CYCLES - 1);
  localparam logic [1:0]  LAST_IDX     = 2'(NUM_PROGS - 1);
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_CYC - 16'd1;

  launch_state_e state_q, state_d;
  logic [7:0]    init_cnt_q, init_cnt_d;
  logic [1:0]    prog_idx_q, prog_idx_d;
  logic [15:0]   cycle_count_q, cycle_count_d;
  logic          timeout_q, timeout_d;
  logic          init_q, busy_q, ready_q, all_done_q;

  logic          run_clr, run_en;
  logic [15:0]   run_cnt;
  logic          normal_exit;

  sat_counter #(.W(16)) u_run_cnt (
    .clk_i (CLK),
    .rst_i (Reset),
    .clr_i (run_clr),
    .en_i  (run_en),
    .q_o   (run_cnt)
  );

  assign normal_exit = Done_if && (PC == prog_end(prog_idx_q));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    prog_idx_d    = prog_idx_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    run_clr       = 1'b0;
    run_en        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d    = S_INIT;
          init_cnt_d = '0;
          run_clr    = 1'b1;
        end
      end
      S_INIT: begin
        init_cnt_d = init_cnt_q + 8'd1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        run_en = 1'b1;
        // A matching end address takes priority over a simultaneous timeout.
        if (normal_exit) begin
          state_d   = S_FINISH;
          timeout_d = 1'b0;
        end else if (run_cnt == TIMEOUT_LAST) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
        end
      end
      S_FINISH: begin
        cycle_count_d = run_cnt;
        if (prog_idx_q == LAST_IDX) begin
          state_d = S_ALL_DONE;
        end else begin
          prog_idx_d = prog_idx_q + 2'd1;
          state_d    = S_IDLE;
        end
      end
      S_ALL_DONE: begin
        state_d = S_ALL_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      init_cnt_q    <= '0;
      prog_idx_q    <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      init_q        <= 1'b0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
      all_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      prog_idx_q    <= prog_idx_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      // Status flags track the state being entered, so they are flops aligned with it.
      init_q        <= (state_d == S_INIT);
      busy_q        <= (state_d == S_INIT) || (state_d == S_RUN);
      ready_q       <= (state_d == S_FINISH);
      all_done_q    <= (state_d == S_ALL_DONE);
    end
  end

  assign Init        = init_q;
  assign Busy        = busy_q;
  assign Ready       = ready_q;
  assign All_done    = all_done_q;
  assign Prog_idx    = prog_idx_q;
  assign Cycle_count = cycle_count_q;
  assign Timeout     = timeout_q;

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher: launch table plus hand-written finish, timeout and reset sequences.
module tb_prog_launcher;

  logic        CLK;
  logic        Reset;
  logic        Start;
  logic        Done_if;
  logic [15:0] PC;
  logic        Init;
  logic        Busy;
  logic [1:0]  Prog_idx;
  logic [15:0] Cycle_count;
  logic        Ready;
  logic        Timeout;
  logic        All_done;

  int total;
  int bad;

  prog_launcher dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Start       (Start),
    .Done_if     (Done_if),
    .PC          (PC),
    .Init        (Init),
    .Busy        (Busy),
    .Prog_idx    (Prog_idx),
    .Cycle_count (Cycle_count),
    .Ready       (Ready),
    .Timeout     (Timeout),
    .All_done    (All_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        start;
    logic        done_if;
    logic [15:0] pc;
    logic        e_init;
    logic        e_busy;
    logic        e_ready;
    logic [1:0]  e_idx;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " Init"},        32'(Init),        32'd0);
    check({tag, " Busy"},        32'(Busy),        32'd0);
    check({tag, " Ready"},       32'(Ready),       32'd0);
    check({tag, " Timeout"},     32'(Timeout),     32'd0);
    check({tag, " All_done"},    32'(All_done),    32'd0);
    check({tag, " Prog_idx"},    32'(Prog_idx),    32'd0);
    check({tag, " Cycle_count"}, 32'(Cycle_count), 32'd0);
  endtask

  // Launch from IDLE and step to the first RUN cycle.
  task automatic launch();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    Reset   = 1'b1;
    Start   = 1'b0;
    Done_if = 1'b0;
    PC      = 16'd0;

    // start, done_if, pc, e_init, e_busy, e_ready, e_idx
    vecs[0] = '{1'b0, 1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 2'd0}; // idle holds
    vecs[1] = '{1'b1, 1'b0, 16'd0,   1'b1, 1'b1, 1'b0, 2'd0}; // INIT cycle 1
    vecs[2] = '{1'b0, 1'b0, 16'd0,   1'b1, 1'b1, 1'b0, 2'd0}; // INIT cycle 2
    vecs[3] = '{1'b0, 1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 2'd0}; // RUN cycle 1
    vecs[4] = '{1'b1, 1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 2'd0}; // Start ignored in RUN
    vecs[5] = '{1'b0, 1'b1, 16'd300, 1'b0, 1'b1, 1'b0, 2'd0}; // other program's end

    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    Reset = 1'b0;
    tick();
    check_all_zero("post_reset");

    // Program 0: table-driven launch, then normal finish in RUN cycle 50.
    for (int i = 0; i < 6; i++) begin
      Start   = vecs[i].start;
      Done_if = vecs[i].done_if;
      PC      = vecs[i].pc;
      tick();
      check($sformatf("vec%0d Init", i),     32'(Init),     32'(vecs[i].e_init));
      check($sformatf("vec%0d Busy", i),     32'(Busy),     32'(vecs[i].e_busy));
      check($sformatf("vec%0d Ready", i),    32'(Ready),    32'(vecs[i].e_ready));
      check($sformatf("vec%0d Prog_idx", i), 32'(Prog_idx), 32'(vecs[i].e_idx));
    end
    Start   = 1'b0;
    Done_if = 1'b0;
    PC      = 16'd0;
    repeat (47) tick();
    check("p0 c50 Busy", 32'(Busy), 32'd1);
    Done_if = 1'b1;
    PC      = 16'd123;
    tick();
    check("p0 finish Ready",   32'(Ready),   32'd1);
    check("p0 finish Busy",    32'(Busy),    32'd0);
    check("p0 finish Timeout", 32'(Timeout), 32'd0);
    Done_if = 1'b0;
    tick();
    check("p0 Ready pulse",  32'(Ready),       32'd0);
    check("p0 Cycle_count",  32'(Cycle_count), 32'd50);
    check("p0 Prog_idx",     32'(Prog_idx),    32'd1);
    check("p0 Timeout",      32'(Timeout),     32'd0);

    // Program 1: program 0's end address must not finish it.
    launch();
    Done_if = 1'b1;
    PC      = 16'd123;
    repeat (10) tick();
    check("p1 wrong pc Busy",  32'(Busy),  32'd1);
    check("p1 wrong pc Ready", 32'(Ready), 32'd0);
    PC = 16'd300;
    tick();
    check("p1 finish Ready", 32'(Ready), 32'd1);
    tick();
    check("p1 Cycle_count", 32'(Cycle_count), 32'd11);
    check("p1 Prog_idx",    32'(Prog_idx),    32'd2);

    // Program 2 with Done_if still high; finishes in its first RUN cycle.
    launch();
    PC = 16'd511;
    tick();
    check("p2 finish Ready",    32'(Ready),    32'd1);
    check("p2 finish All_done", 32'(All_done), 32'd0);
    tick();
    check("p2 All_done",    32'(All_done),    32'd1);
    check("p2 Cycle_count", 32'(Cycle_count), 32'd1);
    check("p2 Prog_idx",    32'(Prog_idx),    32'd2);
    check("p2 Busy",        32'(Busy),        32'd0);
    Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("all_done start%0d Init", i),     32'(Init),     32'd0);
      check($sformatf("all_done start%0d All_done", i), 32'(All_done), 32'd1);
    end
    Start   = 1'b0;
    Done_if = 1'b0;

    // Timeout on program 0 while Done_if is high at another program's end address.
    Reset = 1'b1;
    #1;
    check_all_zero("reset2");
    Reset = 1'b0;
    Done_if = 1'b1;
    PC      = 16'd300;
    launch();
    repeat (3999) tick();
    check("to c4000 Busy",  32'(Busy),  32'd1);
    check("to c4000 Ready", 32'(Ready), 32'd0);
    tick();
    check("to finish Ready",   32'(Ready),   32'd1);
    check("to finish Timeout", 32'(Timeout), 32'd1);
    tick();
    check("to Cycle_count", 32'(Cycle_count), 32'd4000);
    check("to Prog_idx",    32'(Prog_idx),    32'd1);
    check("to idle Busy",   32'(Busy),        32'd0);
    check("to idle Init",   32'(Init),        32'd0);

    // Program 1 running: Timeout stays sticky, then reset abandons it.
    Done_if = 1'b0;
    PC      = 16'd0;
    launch();
    repeat (5) tick();
    check("sticky Timeout", 32'(Timeout), 32'd1);
    check("p1 run Busy",    32'(Busy),    32'd1);
    Reset = 1'b1;
    #1;
    check_all_zero("mid_run_reset");
    Reset = 1'b0;
    Start = 1'b1;
    tick();
    check("relaunch Init",     32'(Init),     32'd1);
    check("relaunch Prog_idx", 32'(Prog_idx), 32'd0);
    Start = 1'b0;
    tick();
    tick();

    // Both exits in RUN cycle 4000: the normal exit wins.
    repeat (3999) tick();
    Done_if = 1'b1;
    PC      = 16'd123;
    tick();
    check("both finish Ready",   32'(Ready),   32'd1);
    check("both finish Timeout", 32'(Timeout), 32'd0);
    Done_if = 1'b0;
    tick();
    check("both Cycle_count", 32'(Cycle_count), 32'd4000);
    check("both Prog_idx",    32'(Prog_idx),    32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
